// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD receive/capture path.
// Pixel type, RGB565 packing, default window and CRC-16/CCITT helpers.
package lcd_pkg;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_CAPTURE,
    ST_DONE
  } cap_state_e;

  localparam int unsigned DEF_WIN_X  = 240;
  localparam int unsigned DEF_WIN_Y  = 120;
  localparam int unsigned DEF_WIN_W  = 320;
  localparam int unsigned DEF_WIN_H  = 240;
  localparam int unsigned DEF_ADDR_W = 17;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  function automatic rgb565_t pack565(input logic [7:0] r, input logic [7:0] g,
                                      input logic [7:0] b);
    rgb565_t p;
    p.r = r[7:3];
    p.g = g[7:2];
    p.b = b[7:3];
    return p;
  endfunction

  // One 16-bit word, MSB first, non-reflected.
  function automatic logic [15:0] crc16_word(input logic [15:0] crc, input logic [15:0] d);
    logic [15:0] c;
    c = crc;
    for (int unsigned i = 0; i < 16; i++) begin
      if (c[15] ^ d[4'(15 - i)]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else                       c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/lcd_sync_edge.sv
// Registers the LCD interface once in the system clock and produces
// registered edge pulses (pixel event, HD/VD/DEN falls) with pixel data aligned.
module lcd_sync_edge
  import lcd_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        nclk_i,
  input  logic        hd_i,
  input  logic        vd_i,
  input  logic        den_i,
  input  logic [23:0] rgb_i,
  output logic        pix_ev_o,
  output logic        hd_fall_o,
  output logic        vd_fall_o,
  output logic        den_fall_o,
  output logic [23:0] rgb_o
);

  logic        nclk_s_q, hd_s_q, vd_s_q, den_s_q;
  logic        nclk_p_q, hd_p_q, vd_p_q, den_p_q;
  logic        pix_ev_q, hd_fall_q, vd_fall_q, den_fall_q;
  logic [23:0] rgb_s_q, rgb_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      nclk_s_q   <= 1'b0;
      hd_s_q     <= 1'b0;
      vd_s_q     <= 1'b0;
      den_s_q    <= 1'b0;
      nclk_p_q   <= 1'b0;
      hd_p_q     <= 1'b0;
      vd_p_q     <= 1'b0;
      den_p_q    <= 1'b0;
      pix_ev_q   <= 1'b0;
      hd_fall_q  <= 1'b0;
      vd_fall_q  <= 1'b0;
      den_fall_q <= 1'b0;
      rgb_s_q    <= '0;
      rgb_q      <= '0;
    end else begin
      nclk_s_q   <= nclk_i;
      hd_s_q     <= hd_i;
      vd_s_q     <= vd_i;
      den_s_q    <= den_i;
      rgb_s_q    <= rgb_i;
      nclk_p_q   <= nclk_s_q;
      hd_p_q     <= hd_s_q;
      vd_p_q     <= vd_s_q;
      den_p_q    <= den_s_q;
      // Data travels with its edge flag so the consumer sees a matched pair.
      pix_ev_q   <= nclk_s_q & ~nclk_p_q & den_s_q;
      hd_fall_q  <= hd_p_q & ~hd_s_q;
      vd_fall_q  <= vd_p_q & ~vd_s_q;
      den_fall_q <= den_p_q & ~den_s_q;
      rgb_q      <= rgb_s_q;
    end
  end

  assign pix_ev_o   = pix_ev_q;
  assign hd_fall_o  = hd_fall_q;
  assign vd_fall_o  = vd_fall_q;
  assign den_fall_o = den_fall_q;
  assign rgb_o      = rgb_q;

endmodule

// File: rtl/lcd_frame_capture.sv
// Captures a WIN_W x WIN_H window of one LCD frame as RGB565 into a linear RAM.
// Optional FRAME_CRC_EN adds a CRC-16/CCITT of the written words on port crc.
module lcd_frame_capture
  import lcd_pkg::*;
#(
  parameter int unsigned WIN_X  = DEF_WIN_X,
  parameter int unsigned WIN_Y  = DEF_WIN_Y,
  parameter int unsigned WIN_W  = DEF_WIN_W,
  parameter int unsigned WIN_H  = DEF_WIN_H,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              NCLK,
  input  logic              HD,
  input  logic              VD,
  input  logic              DEN,
  input  logic [7:0]        R,
  input  logic [7:0]        G,
  input  logic [7:0]        B,
  input  logic              start,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef FRAME_CRC_EN
  ,
  output logic [15:0]       crc
`endif
);

  localparam logic [10:0]       X_LO = 11'(WIN_X);
  localparam logic [10:0]       X_HI = 11'(WIN_X + WIN_W);
  localparam logic [9:0]        Y_LO = 10'(WIN_Y);
  localparam logic [9:0]        Y_HI = 10'(WIN_Y + WIN_H);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WIN_W * WIN_H - 1);

  cap_state_e        state_q, state_d;
  logic [10:0]       col_q;
  logic [9:0]        row_q;
  logic [ADDR_W-1:0] cnt_q, wr_addr_q;
  logic [15:0]       wr_data_q;
  logic              wr_en_q, err_q;
  logic              pix_ev, hd_fall, vd_fall, den_fall, in_win, wr_fire;
  logic [23:0]       rgb;
  rgb565_t           pix;

  lcd_sync_edge u_sync (
    .clk_i     (CLK),
    .rst_ni    (RST_n),
    .nclk_i    (NCLK),
    .hd_i      (HD),
    .vd_i      (VD),
    .den_i     (DEN),
    .rgb_i     ({R, G, B}),
    .pix_ev_o  (pix_ev),
    .hd_fall_o (hd_fall),
    .vd_fall_o (vd_fall),
    .den_fall_o(den_fall),
    .rgb_o     (rgb)
  );

  assign pix     = pack565(rgb[23:16], rgb[15:8], rgb[7:0]);
  assign in_win  = (col_q >= X_LO) && (col_q < X_HI) && (row_q >= Y_LO) && (row_q < Y_HI);
  assign wr_fire = (state_q == ST_CAPTURE) && pix_ev && in_win;

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_ARM;
      ST_ARM: begin
        busy = 1'b1;
        if (vd_fall) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        busy = 1'b1;
        if (vd_fall)                       state_d = ST_IDLE;
        else if (wr_fire && cnt_q == LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default:    state_d = ST_IDLE;
    endcase
  end

`ifdef FRAME_CRC_EN
  logic [15:0] crc_q;
  assign crc = crc_q;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q   <= ST_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      cnt_q     <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef FRAME_CRC_EN
      crc_q     <= CRC_INIT;
`endif
    end else begin
      state_q <= state_d;
      wr_en_q <= wr_fire;
      if (hd_fall)     col_q <= '0;
      else if (pix_ev) col_q <= col_q + 11'd1;
      if (vd_fall)       row_q <= '0;
      else if (den_fall) row_q <= row_q + 10'd1;
      if (state_q == ST_IDLE && start) begin
        err_q     <= 1'b0;
        wr_addr_q <= '0;
        cnt_q     <= '0;
`ifdef FRAME_CRC_EN
        crc_q     <= CRC_INIT;
`endif
      end
      if (state_q == ST_CAPTURE && vd_fall) err_q <= 1'b1;
      // Raster order makes the window linear, so a running count is the address.
      if (wr_fire) begin
        wr_addr_q <= cnt_q;
        wr_data_q <= pix;
        cnt_q     <= cnt_q + 1'b1;
`ifdef FRAME_CRC_EN
        crc_q     <= crc16_word(crc_q, pix);
`endif
      end
    end
  end

  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_en   = wr_en_q;
  assign err     = err_q;

endmodule
